inst_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction controller.
- Owns the PC, issues one 32-bit instruction request at a time to instruction memory over a valid/ready request plus valid response interface.
- Holds each returned instruction stable with its PC until the decode/execute side accepts it.
- Applies redirects (taken branch, jal, jalr), discarding any stale in-flight response.

---
 rtl/inst_fetch_unit_pkg.sv | 24 ++
 rtl/inst_fetch_unit.sv | 97 +++++++++
 tb/tb_inst_fetch_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-stage types and constants: address/instruction widths, reset PC
// and the fetch FSM state encoding.
package inst_fetch_unit_pkg;

    localparam int unsigned ADDR_WIDTH = 64;
    localparam int unsigned INST_WIDTH = 32;
    localparam int unsigned INST_BYTES = 4;

    localparam logic [ADDR_WIDTH-1:0] PC_RESET_VALUE = 64'h0000_0000_8000_0000;

    typedef enum logic [2:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_DROP,
        FETCH_HOLD
    } fetch_state_enum;

    // Instruction addresses are word aligned; low two bits are forced to zero.
    function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding instruction request at a time,
// holds the returned instruction until consumed, and applies redirects.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] PC_RESET = PC_RESET_VALUE
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    fetch_state_enum       state;
    fetch_state_enum       state_nxt;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic [ADDR_WIDTH-1:0] redirect_tgt;
    logic                  handshake;
    logic                  capture;

    assign handshake    = imem_req_valid & imem_req_ready;
    assign redirect_tgt = align_pc(redirect_pc);

    // Next state / next PC; a redirect outside IDLE always retargets the PC.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        if (redirect_valid && (state != FETCH_IDLE)) begin
            pc_nxt = redirect_tgt;
        end
        case (state)
            FETCH_IDLE: state_nxt = FETCH_REQ;
            FETCH_REQ: begin
                if (handshake) begin
                    state_nxt = redirect_valid ? FETCH_DROP : FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (redirect_valid) begin
                    state_nxt = imem_resp_valid ? FETCH_REQ : FETCH_DROP;
                end else if (imem_resp_valid) begin
                    capture   = 1'b1;
                    state_nxt = FETCH_HOLD;
                end
            end
            FETCH_DROP: begin
                if (imem_resp_valid) begin
                    state_nxt = FETCH_REQ;
                end
            end
            FETCH_HOLD: begin
                if (redirect_valid) begin
                    state_nxt = FETCH_REQ;
                end else if (inst_valid && inst_ready) begin
                    pc_nxt    = pc + ADDR_WIDTH'(INST_BYTES);
                    state_nxt = FETCH_REQ;
                end
            end
            default: state_nxt = FETCH_IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= FETCH_IDLE;
            pc             <= PC_RESET;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= '0;
            inst_valid     <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            imem_req_valid <= (state_nxt == FETCH_REQ);
            imem_req_addr  <= (state_nxt == FETCH_REQ) ? pc_nxt : '0;
            inst_valid     <= (state_nxt == FETCH_HOLD);
            if (capture) begin
                inst    <= imem_resp_data;
                inst_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: transaction-level model checked every cycle
// plus hand-computed literal expectations.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    // Second instance exercising PC wrap-around.
    logic        rst2;
    logic        r2_req_valid;
    logic [63:0] r2_req_addr;
    logic        r2_req_ready;
    logic        r2_resp_valid;
    logic [31:0] r2_resp_data;
    logic        r2_inst_valid;
    logic [31:0] r2_inst;
    logic [63:0] r2_inst_pc;
    logic        r2_inst_ready;
    logic        r2_redirect_valid;
    logic [63:0] r2_redirect_pc;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    inst_fetch_unit #(.PC_RESET(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk             (clk),
        .rst             (rst2),
        .imem_req_valid  (r2_req_valid),
        .imem_req_addr   (r2_req_addr),
        .imem_req_ready  (r2_req_ready),
        .imem_resp_valid (r2_resp_valid),
        .imem_resp_data  (r2_resp_data),
        .inst_valid      (r2_inst_valid),
        .inst            (r2_inst),
        .inst_pc         (r2_inst_pc),
        .inst_ready      (r2_inst_ready),
        .redirect_valid  (r2_redirect_valid),
        .redirect_pc     (r2_redirect_pc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: fetch address, request pending, outstanding/stale flags, held instruction.
    logic [63:0] m_pc;
    logic        m_started, m_req, m_out, m_stale, m_hv;
    logic [31:0] m_inst;
    logic [63:0] m_ipc;

    always @(posedge clk) begin
        logic [63:0] tgt;
        tgt = {redirect_pc[63:2], 2'b00};
        if (rst) begin
            m_pc = PC_RST; m_started = 0; m_req = 0; m_out = 0; m_stale = 0;
            m_hv = 0; m_inst = '0; m_ipc = '0;
        end else if (!m_started) begin
            m_started = 1; m_req = 1;
        end else if (m_req) begin
            if (redirect_valid) m_pc = tgt;
            if (imem_req_ready) begin
                m_req = 0; m_out = 1; m_stale = redirect_valid;
            end
        end else if (m_out) begin
            if (imem_resp_valid) begin
                m_out = 0;
                if (m_stale || redirect_valid) m_req = 1;
                else begin
                    m_hv = 1; m_inst = imem_resp_data; m_ipc = m_pc;
                end
            end else if (redirect_valid) m_stale = 1;
            if (redirect_valid) m_pc = tgt;
        end else if (m_hv) begin
            if (redirect_valid) begin
                m_hv = 0; m_pc = tgt; m_req = 1;
            end else if (inst_ready) begin
                m_hv = 0; m_pc = m_pc + 64'd4; m_req = 1;
            end
        end
        #1;
        check("req_valid", 64'(imem_req_valid), 64'(m_req));
        check("req_addr", imem_req_addr, m_req ? m_pc : 64'd0);
        check("inst_valid", 64'(inst_valid), 64'(m_hv));
        check("inst", 64'(inst), 64'(m_inst));
        check("inst_pc", inst_pc, m_ipc);
    end

    task automatic cyc(input logic rdy, input logic rv, input logic [31:0] d,
                       input logic ir, input logic rdv, input logic [63:0] rpc);
        @(negedge clk);
        imem_req_ready  = rdy;
        imem_resp_valid = rv;
        imem_resp_data  = d;
        inst_ready      = ir;
        redirect_valid  = rdv;
        redirect_pc     = rpc;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1; rst2 = 1;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
        inst_ready = 0; redirect_valid = 0; redirect_pc = '0;
        r2_req_ready = 0; r2_resp_valid = 0; r2_resp_data = '0;
        r2_inst_ready = 0; r2_redirect_valid = 0; r2_redirect_pc = '0;

        repeat (2) @(posedge clk);
        #2;
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_req_addr", imem_req_addr, 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_inst_pc", inst_pc, 64'd0);

        @(negedge clk); rst = 0;
        @(posedge clk); #2;
        check("first_req_valid", 64'(imem_req_valid), 64'd1);
        check("first_req_addr", imem_req_addr, 64'h8000_0000);

        // basic fetch
        cyc(1, 0, 32'h0, 1, 0, 64'h0);
        check("wait_req_valid", 64'(imem_req_valid), 64'd0);
        cyc(0, 1, 32'h0000_0093, 1, 0, 64'h0);
        check("t1_inst_valid", 64'(inst_valid), 64'd1);
        check("t1_inst", 64'(inst), 64'h93);
        check("t1_inst_pc", inst_pc, 64'h8000_0000);
        cyc(0, 0, 32'h0, 1, 0, 64'h0);
        check("t1_next_addr", imem_req_addr, 64'h8000_0004);

        // backpressure in HOLD
        cyc(1, 0, 32'h0, 0, 0, 64'h0);
        cyc(0, 1, 32'h0011_2233, 0, 0, 64'h0);
        repeat (5) cyc(0, 0, 32'h0, 0, 0, 64'h0);
        check("t2_inst", 64'(inst), 64'h0011_2233);
        check("t2_inst_pc", inst_pc, 64'h8000_0004);
        check("t2_req_valid", 64'(imem_req_valid), 64'd0);
        cyc(0, 0, 32'h0, 1, 0, 64'h0);
        check("t2_next_addr", imem_req_addr, 64'h8000_0008);

        // redirect in WAIT drops the response
        cyc(1, 0, 32'h0, 0, 0, 64'h0);
        cyc(0, 0, 32'h0, 0, 1, 64'h8000_0103);
        cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 64'h0);
        check("t3_inst_valid", 64'(inst_valid), 64'd0);
        check("t3_addr", imem_req_addr, 64'h8000_0100);

        // redirect beats inst_ready in HOLD
        cyc(1, 0, 32'h0, 0, 0, 64'h0);
        cyc(0, 1, 32'h0000_0013, 0, 0, 64'h0);
        check("t4_inst_pc", inst_pc, 64'h8000_0100);
        cyc(0, 0, 32'h0, 1, 1, 64'h8000_0200);
        check("t4_addr", imem_req_addr, 64'h8000_0200);

        // request stall, redirect before acceptance
        repeat (3) cyc(0, 0, 32'h0, 0, 0, 64'h0);
        check("t5_stall_valid", 64'(imem_req_valid), 64'd1);
        check("t5_stall_addr", imem_req_addr, 64'h8000_0200);
        cyc(0, 0, 32'h0, 0, 1, 64'h8000_0300);
        check("t5_redir_addr", imem_req_addr, 64'h8000_0300);
        cyc(1, 0, 32'h0, 0, 0, 64'h0);
        cyc(0, 1, 32'h0000_0513, 0, 0, 64'h0);
        check("t5_inst_pc", inst_pc, 64'h8000_0300);
        cyc(0, 1, 32'hFFFF_FFFF, 0, 0, 64'h0);
        check("t5_hold_ignore", 64'(inst), 64'h513);
        cyc(0, 0, 32'h0, 1, 0, 64'h0);
        check("t5_next_addr", imem_req_addr, 64'h8000_0304);

        // redirect on the accepting cycle, stray response in REQ
        cyc(1, 0, 32'h0, 0, 1, 64'h8000_0400);
        check("t6_drop_valid", 64'(imem_req_valid), 64'd0);
        cyc(0, 1, 32'h0BAD_0BAD, 0, 0, 64'h0);
        check("t6_addr", imem_req_addr, 64'h8000_0400);
        check("t6_inst_valid", 64'(inst_valid), 64'd0);
        cyc(0, 1, 32'h0000_1234, 0, 0, 64'h0);
        check("t6_req_ignore", imem_req_addr, 64'h8000_0400);

        // redirect and response together in WAIT
        cyc(1, 0, 32'h0, 0, 0, 64'h0);
        cyc(0, 1, 32'hCAFE_CAFE, 0, 1, 64'h8000_0500);
        check("t7_addr", imem_req_addr, 64'h8000_0500);
        check("t7_inst_valid", 64'(inst_valid), 64'd0);

        // async reset in WAIT, late response ignored
        cyc(1, 0, 32'h0, 0, 0, 64'h0);
        cyc(0, 0, 32'h0, 0, 0, 64'h0);
        @(negedge clk);
        rst = 1;
        #1;
        check("ar_req_valid", 64'(imem_req_valid), 64'd0);
        check("ar_req_addr", imem_req_addr, 64'd0);
        check("ar_inst_valid", 64'(inst_valid), 64'd0);
        check("ar_inst", 64'(inst), 64'd0);
        check("ar_inst_pc", inst_pc, 64'd0);
        @(negedge clk);
        rst = 0; imem_resp_valid = 1; imem_resp_data = 32'hDEAD_0001;
        @(posedge clk); #2;
        check("ar_restart_valid", 64'(imem_req_valid), 64'd1);
        check("ar_restart_addr", imem_req_addr, 64'h8000_0000);
        check("ar_late_ignored", 64'(inst_valid), 64'd0);
        cyc(0, 0, 32'h0, 0, 0, 64'h0);

        // PC wrap on the second instance
        @(negedge clk); rst2 = 0;
        @(posedge clk); #2;
        check("wrap_first_addr", r2_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk); r2_req_ready = 1;
        @(posedge clk); #2;
        check("wrap_wait_valid", 64'(r2_req_valid), 64'd0);
        @(negedge clk); r2_req_ready = 0; r2_resp_valid = 1; r2_resp_data = 32'h0000_0297;
        @(posedge clk); #2;
        check("wrap_inst", 64'(r2_inst), 64'h297);
        check("wrap_inst_pc", r2_inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk); r2_resp_valid = 0; r2_inst_ready = 1;
        @(posedge clk); #2;
        check("wrap_next_valid", 64'(r2_req_valid), 64'd1);
        check("wrap_next_addr", r2_req_addr, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
